instruction_fetch_unit: RTL
===========================

# instruction_fetch_unit

Fetch stage of the 5-stage RISC-V pipeline. It holds the fetch PC and issues word reads to the instruction cache using the codebase's read/busywait protocol. It presents a registered instruction, PC and PC+4 to the IF/ID register. It consumes the execute stage's redirect (`branch_or_jump_signal` / `branch_jump_addres`) and the hazard unit's stall, flushing or discarding in-flight fetches as required.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.

Ports:
- `CLK` in 1: single clock; all state updates on the rising edge.
- `RESET` in 1: asynchronous, active-high reset.
- `stall_in` in 1: hazard unit stall (load-use); hold the IF outputs.
- `branch_or_jump_signal` in 1: redirect request from execute.
- `branch_jump_addres` in 32: redirect target.
- `imem_readdata` in 32: cache read data; valid on a completing edge.
- `imem_busywait` in 1: cache busy; a read completes at an edge where `imem_read`=1 and `imem_busywait`=0.
- `imem_read` out 1: read request.
- `imem_address` out 32: read address, word aligned.
- `instruction` out 32: fetched instruction to IF/ID.
- `PC` out 32: address of `instruction`.
- `INCREMENTED_PC_by_four` out 32: `PC`+4, mod 2^32.
- `instr_valid` out 1: `instruction` is real (0 = bubble).
- `flush` out 1: one-cycle pulse after a redirect is accepted.

## Operation
Registers:
- `fetch_pc`
- output register O = {`instruction`, `PC`, `instr_valid`}
- skid register S = {data, pc}
- `pending_target`
- `state`

States: IDLE, FETCH, HOLD, DISCARD.
- **IDLE** (reset state): `imem_read`=0. Moves to FETCH on the next edge.
- **FETCH**: `imem_read`=1, `imem_address`=`fetch_pc`. Priority at each edge is redirect, then completion, then no completion:
  - Redirect with `imem_busywait`=1: `pending_target` <= target & ~3; go to DISCARD.
  - Redirect otherwise: `fetch_pc` <= target & ~3; stay in FETCH.
  - Any redirect also sets O.valid <= 0, drops S, and sets `flush` <= 1 for one cycle. Redirect overrides `stall_in`.
  - Completion with (`stall_in`=0 or O.valid=0): O <= {data, `fetch_pc`, 1}; `fetch_pc` += 4.
  - Completion with `stall_in`=1 and O.valid=1: S <= {data, `fetch_pc`}; `fetch_pc` += 4; go to HOLD.
  - No completion: if `stall_in`=0, O.valid <= 0 (bubble); if `stall_in`=1, O is held.
- **HOLD**: `imem_read`=0; O is held.
  - `stall_in`=0: O <= {S, 1}; go to FETCH.
  - Redirect: handled as in FETCH (no access in flight); go to FETCH.
- **DISCARD**: `imem_read`=1, `imem_address`=`fetch_pc`, unchanged, so the cache sees a stable address.
  - Completion: data is dropped; `fetch_pc` <= `pending_target`; go to FETCH.
  - Further redirect: overwrites `pending_target` and pulses `flush`; stay in DISCARD.
  - O.valid stays 0.
- Target bits [1:0] are ignored (cleared). PC arithmetic wraps modulo 2^32.

## Timing
- Reset values:
  - state=IDLE, `fetch_pc`=`RESET_PC`.
  - O.valid=0, `instruction`=32'h0000_0013 (NOP), `PC`=`RESET_PC`.
  - `flush`=0, `imem_read`=0. S is cleared.
- RESET asserted at any time, including mid-DISCARD or HOLD, returns to this state immediately. Any in-flight cache completion is ignored.
- Zero-wait cache: first `instr_valid` at the 2nd edge after RESET deasserts, then one instruction per cycle.
- Fetch latency is 1 + busywait cycles per instruction.
- Redirect: target is requested on the cycle after the redirect edge when no access is in flight. Otherwise it is requested on the cycle after the in-flight access completes.
- `imem_read`, `imem_address`, `flush` and all IF outputs are registered or decoded from state only. There is no combinational path from `stall_in` or the redirect inputs to `imem_address`.

## Structure
- Shared package `if_pkg`:
  - state enum {IDLE, FETCH, HOLD, DISCARD}
  - `NOP_INSTR` = 32'h0000_0013
  - `WORD_MASK` = ~32'h3
- Single module. The skid register and PC adders are inline; no sub-module is warranted.

## Test plan
- Reset release, zero-wait cache holding words at 0,4,8 → `instr_valid`=1 from the 2nd edge; `PC` = 0,4,8 on consecutive cycles; `INCREMENTED_PC_by_four` = 4,8,12.
- Cache busywait high for 3 cycles on every access → one valid instruction every 4 cycles, `instr_valid`=0 in between, `imem_address` stable for the whole access.
- O valid at `PC`=8, `stall_in`=1 for 3 cycles while the read of 12 completes → outputs stay at 8, `imem_read`=0 in HOLD; after release O=12, then the next request is at 16.
- Redirect to 0x100 with zero-wait cache → `flush`=1 for one cycle, `instr_valid`=0, next valid `PC`=0x100.
- Redirect to 0x200 while the read of 0x20 is busy → `imem_address` stays 0x20 until completion, 0x20 is never presented valid, next request is at 0x200.
- Redirect to 0x103 together with `stall_in`=1 → fetch at 0x100, stall ignored. RESET asserted mid-DISCARD → IDLE, `PC`=`RESET_PC`, `imem_read`=0.

Source files
------------

// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared types and constants for the instruction fetch stage
package if_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } if_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - fetch PC, icache read/busywait handshake, registered IF outputs
module instruction_fetch_unit
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        stall_in,
  input  logic        branch_or_jump_signal,
  input  logic [31:0] branch_jump_addres,
  input  logic [31:0] imem_readdata,
  input  logic        imem_busywait,
  output logic        imem_read,
  output logic [31:0] imem_address,
  output logic [31:0] instruction,
  output logic [31:0] PC,
  output logic [31:0] INCREMENTED_PC_by_four,
  output logic        instr_valid,
  output logic        flush
);

  if_state_e   r_state;
  logic [31:0] r_fetch_pc;
  logic [31:0] r_instr;
  logic [31:0] r_pc;
  logic        r_valid;
  logic [31:0] r_skid_data;
  logic [31:0] r_skid_pc;
  logic [31:0] r_pending;
  logic        r_flush;

  logic        w_read;
  logic [31:0] w_target;

  // Read request depends on state only, so the address never sees stall/redirect combinationally.
  assign w_read   = (r_state == FETCH) || (r_state == DISCARD);
  assign w_target = branch_jump_addres & WORD_MASK;

  assign imem_read              = w_read;
  assign imem_address           = r_fetch_pc;
  assign instruction            = r_instr;
  assign PC                     = r_pc;
  assign INCREMENTED_PC_by_four = r_pc + 32'd4;
  assign instr_valid            = r_valid;
  assign flush                  = r_flush;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state     <= IDLE;
      r_fetch_pc  <= RESET_PC;
      r_instr     <= NOP_INSTR;
      r_pc        <= RESET_PC;
      r_valid     <= 1'b0;
      r_skid_data <= 32'd0;
      r_skid_pc   <= 32'd0;
      r_pending   <= 32'd0;
      r_flush     <= 1'b0;
    end else begin
      r_flush <= 1'b0;
      case (r_state)
        IDLE: r_state <= FETCH;

        FETCH: begin
          if (branch_or_jump_signal) begin
            r_valid     <= 1'b0;
            r_flush     <= 1'b1;
            r_skid_data <= 32'd0;
            r_skid_pc   <= 32'd0;
            if (imem_busywait) begin
              r_pending <= w_target;
              r_state   <= DISCARD;
            end else begin
              r_fetch_pc <= w_target;
            end
          end else if (!imem_busywait) begin
            r_fetch_pc <= r_fetch_pc + 32'd4;
            if (!stall_in || !r_valid) begin
              r_instr <= imem_readdata;
              r_pc    <= r_fetch_pc;
              r_valid <= 1'b1;
            end else begin
              // IF/ID is stalled on a live instruction: park the new word.
              r_skid_data <= imem_readdata;
              r_skid_pc   <= r_fetch_pc;
              r_state     <= HOLD;
            end
          end else if (!stall_in) begin
            r_valid <= 1'b0;
          end
        end

        HOLD: begin
          if (branch_or_jump_signal) begin
            r_valid     <= 1'b0;
            r_flush     <= 1'b1;
            r_skid_data <= 32'd0;
            r_skid_pc   <= 32'd0;
            r_fetch_pc  <= w_target;
            r_state     <= FETCH;
          end else if (!stall_in) begin
            r_instr <= r_skid_data;
            r_pc    <= r_skid_pc;
            r_valid <= 1'b1;
            r_state <= FETCH;
          end
        end

        DISCARD: begin
          // Address stays put until the stale access drains; its data is dropped.
          if (branch_or_jump_signal) begin
            r_flush <= 1'b1;
            if (imem_busywait) begin
              r_pending <= w_target;
            end else begin
              r_fetch_pc <= w_target;
              r_state    <= FETCH;
            end
          end else if (!imem_busywait) begin
            r_fetch_pc <= r_pending;
            r_state    <= FETCH;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
